// File: rtl/line_clear_engine_if.sv
// Control handshake and board row-port bundle between line_clear_engine and its environment.
// master is the engine side; slave is the board owner / game controller side.
interface line_clear_engine_if #(
  parameter int COLS = 10,
  parameter int AW   = 5
);
  logic            start;
  logic            score_clr;
  logic            row_re;
  logic [AW-1:0]   row_raddr;
  logic [COLS-1:0] row_rdata;
  logic            row_we;
  logic [AW-1:0]   row_waddr;
  logic [COLS-1:0] row_wdata;
  logic            busy;
  logic            done;
  logic [AW-1:0]   lines_cleared;
  logic [15:0]     score;

  modport master (
    input  start, score_clr, row_rdata,
    output row_re, row_raddr, row_we, row_waddr, row_wdata,
           busy, done, lines_cleared, score
  );

  modport slave (
    output start, score_clr, row_rdata,
    input  row_re, row_raddr, row_we, row_waddr, row_wdata,
           busy, done, lines_cleared, score
  );
endinterface

// File: rtl/line_clear_engine.sv
// Post-lock board compactor: reads rows bottom-up, drops full rows, writes kept rows down,
// zero-fills the top, then reports lines cleared and updates a saturating score.
module line_clear_engine #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int AW   = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  line_clear_engine_if.master   bus
);

  typedef enum logic [2:0] {IDLE, RD, EVAL, FILL, DONE} state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_t        state_reg;
  logic [AW-1:0] rd_reg;
  logic [AW-1:0] wr_reg;
  logic [AW-1:0] cnt_reg;
  logic [AW-1:0] raddr_reg;
  logic [AW-1:0] lines_reg;
  logic          re_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [15:0]   score_reg;

  logic          row_full;
  logic          keep_row;
  logic          we;
  logic [AW-1:0] cnt_next;
  logic [3:0]    inc;
  logic [16:0]   score_sum;
  logic [15:0]   score_next;

  assign row_full = &bus.row_rdata;
  assign keep_row = (state_reg == EVAL) && !row_full;
  assign cnt_next = cnt_reg + AW'(row_full);

  // The write must share the EVAL cycle with the read data, so the write port is decoded, not registered.
  assign we            = keep_row || (state_reg == FILL);
  assign bus.row_we    = we;
  assign bus.row_waddr = we ? wr_reg : '0;
  assign bus.row_wdata = keep_row ? bus.row_rdata : '0;

  always_comb begin
    case (cnt_reg)
      AW'(0):  inc = 4'd0;
      AW'(1):  inc = 4'd1;
      AW'(2):  inc = 4'd3;
      AW'(3):  inc = 4'd5;
      default: inc = 4'd8;
    endcase
  end

  assign score_sum  = {1'b0, score_reg} + 17'(inc);
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      rd_reg    <= '0;
      wr_reg    <= '0;
      cnt_reg   <= '0;
      raddr_reg <= '0;
      lines_reg <= '0;
      re_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      score_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            rd_reg    <= LAST_ROW;
            wr_reg    <= LAST_ROW;
            cnt_reg   <= '0;
            re_reg    <= 1'b1;
            raddr_reg <= LAST_ROW;
            busy_reg  <= 1'b1;
            state_reg <= RD;
          end
        end
        RD: begin
          re_reg    <= 1'b0;
          state_reg <= EVAL;
        end
        EVAL: begin
          cnt_reg <= cnt_next;
          if (!row_full) wr_reg <= wr_reg - 1'b1;
          if (rd_reg == '0) begin
            raddr_reg <= '0;
            if (cnt_next != '0) begin
              state_reg <= FILL;
            end else begin
              done_reg  <= 1'b1;
              lines_reg <= cnt_next;
              state_reg <= DONE;
            end
          end else begin
            rd_reg    <= rd_reg - 1'b1;
            re_reg    <= 1'b1;
            raddr_reg <= rd_reg - 1'b1;
            state_reg <= RD;
          end
        end
        FILL: begin
          if (wr_reg == '0) begin
            done_reg  <= 1'b1;
            lines_reg <= cnt_reg;
            state_reg <= DONE;
          end else begin
            wr_reg <= wr_reg - 1'b1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          score_reg <= score_next;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
      // A clear takes priority over the DONE increment above.
      if (bus.score_clr) score_reg <= '0;
    end
  end

  assign bus.row_re        = re_reg;
  assign bus.row_raddr     = raddr_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.lines_cleared = lines_reg;
  assign bus.score         = score_reg;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: a board model serves the row port, expected
// writes and pass results are queued at stimulus time and popped as the DUT produces them.
module tb_line_clear_engine;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;

  typedef struct packed {
    logic [7:0]    cyc;
    logic [AW-1:0] lines;
    logic [15:0]   score;
  } res_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  line_clear_engine_if #(.COLS(COLS), .AW(AW)) bus ();

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [COLS-1:0]      board [ROWS];
  logic [COLS-1:0]      img   [ROWS];
  logic                 load = 1'b0;
  logic [AW+COLS-1:0]   wr_q[$];
  res_t                 res_q[$];
  logic [AW+COLS-1:0]   exp_w;
  logic [15:0]          exp_score = 16'h0;
  int                   n_checks = 0;
  int                   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] add_score(input logic [15:0] s, input int n);
    int inc;
    int t;
    inc = (n == 0) ? 0 : (n == 1) ? 1 : (n == 2) ? 3 : (n == 3) ? 5 : 8;
    t = int'(s) + inc;
    return (t > 65535) ? 16'hFFFF : 16'(t);
  endfunction

  // Board memory with a synchronous read port, as the real board presents it.
  always @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < ROWS; r++) board[r] <= img[r];
    end else if (bus.row_we) begin
      board[bus.row_waddr] <= bus.row_wdata;
    end
    if (bus.row_re) bus.row_rdata <= board[bus.row_raddr];
  end

  always @(negedge clk) begin
    if (resetn && bus.row_we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'(bus.row_waddr), 32'hFFFF_FFFF);
      end else begin
        exp_w = wr_q.pop_front();
        check("waddr", 32'(bus.row_waddr), 32'(exp_w[AW+COLS-1:COLS]));
        check("wdata", 32'(bus.row_wdata), 32'(exp_w[COLS-1:0]));
      end
      check("re_we_excl", 32'(bus.row_re), 32'd0);
    end
  end

  // Compacted image: kept rows stacked from the bottom, zeros above; one write per row, 19 down to 0.
  task automatic prep(output int n);
    logic [COLS-1:0] nb [ROWS];
    int k;
    n = 0;
    k = ROWS - 1;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (&img[i]) n++;
      else begin
        nb[k] = img[i];
        k--;
      end
    end
    for (int i = k; i >= 0; i--) nb[i] = '0;
    for (int i = ROWS - 1; i >= 0; i--) wr_q.push_back({AW'(i), nb[i]});
  endtask

  task automatic load_and_start();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic run_pass(input string name, input int start_at, input bit clr);
    int   n;
    int   cyc;
    res_t r;
    prep(n);
    exp_score = clr ? 16'h0 : add_score(exp_score, n);
    r.cyc   = 8'(2 * ROWS + 1 + n);
    r.lines = AW'(n);
    r.score = exp_score;
    res_q.push_back(r);
    load_and_start();
    cyc = 1;
    check({name, "_busy_c1"}, 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 3 * ROWS + 8) begin
      bus.start = (cyc == start_at);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    r = res_q.pop_front();
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_done_cycle"}, 32'(cyc), 32'(r.cyc));
    check({name, "_lines"}, 32'(bus.lines_cleared), 32'(r.lines));
    bus.score_clr = clr;
    @(negedge clk);
    bus.score_clr = 1'b0;
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({name, "_score"}, 32'(bus.score), 32'(r.score));
    check({name, "_lines_held"}, 32'(bus.lines_cleared), 32'(r.lines));
    check({name, "_writes_left"}, 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    $display("pass %s: lines=%0d score=%04h done_cycle=%0d", name, bus.lines_cleared, bus.score, cyc);
  endtask

  task automatic set_img(input logic [COLS-1:0] fill);
    for (int i = 0; i < ROWS; i++) img[i] = fill;
  endtask

  task automatic set_four();
    set_img('0);
    for (int i = 16; i < ROWS; i++) img[i] = '1;
    img[15] = 10'h155;
  endtask

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.score_clr = 1'b0;
    set_img('0);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_re", 32'(bus.row_re), 32'd0);
    check("rst_we", 32'(bus.row_we), 32'd0);
    check("rst_raddr", 32'(bus.row_raddr), 32'd0);
    check("rst_waddr", 32'(bus.row_waddr), 32'd0);
    check("rst_wdata", 32'(bus.row_wdata), 32'd0);
    check("rst_lines", 32'(bus.lines_cleared), 32'd0);
    check("rst_score", 32'(bus.score), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    set_img('0);
    run_pass("empty", 0, 1'b0);

    set_img('0);
    img[19] = '1;
    img[18] = 10'b0000000001;
    run_pass("one", 0, 1'b0);

    set_four();
    run_pass("four", 0, 1'b0);

    set_img('0);
    img[19] = '1;
    img[18] = 10'h2AA;
    img[17] = '1;
    img[16] = 10'h0F0;
    run_pass("gap", 0, 1'b0);

    set_img('1);
    run_pass("all_full", 0, 1'b0);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < ROWS; i++)
        img[i] = ($urandom_range(0, 2) == 0) ? '1 : COLS'($urandom);
      run_pass($sformatf("rand%0d", p), 0, 1'b0);
    end

    set_four();
    run_pass("start_busy", 7, 1'b0);

    @(negedge clk) bus.score_clr = 1'b1;
    @(negedge clk) bus.score_clr = 1'b0;
    exp_score = 16'h0;
    check("clr_idle_score", 32'(bus.score), 32'(exp_score));

    set_four();
    run_pass("pre_reset", 0, 1'b0);

    // Abort a pass at cycle 10 with the asynchronous reset.
    set_four();
    prep(n);
    load_and_start();
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_we", 32'(bus.row_we), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_re", 32'(bus.row_re), 32'd0);
    check("abort_score", 32'(bus.score), 32'd0);
    exp_score = 16'h0;
    wr_q.delete();
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);

    set_img('0);
    img[19] = '1;
    img[18] = 10'h3FE;
    run_pass("after_reset", 0, 1'b0);

    force dut.score_reg = 16'hFFFC;
    @(negedge clk);
    release dut.score_reg;
    @(negedge clk);
    exp_score = 16'hFFFC;
    set_four();
    run_pass("saturate", 0, 1'b0);
    set_four();
    run_pass("saturate_hold", 0, 1'b0);

    set_img('0);
    img[19] = '1;
    run_pass("clr_at_done", 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
